// File: rtl/tomasula_types.sv
// ============================================================================
// Module      : tomasula_types (package)
// Description : Shared Tomasulo datapath types: opcode enum, dispatch word
//               (res_word_t), ALU word (alu_word_t) and station-count
//               defaults used by the reservation-station scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tomasula_types;

    // Default number of reservation stations served by one ALU
    localparam int NUM_RS_DEFAULT = 4;
    localparam int RS_IDX_W       = $clog2(NUM_RS_DEFAULT);

    // Station index sized for the default configuration
    typedef logic [RS_IDX_W-1:0] rs_idx_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_AND = 2'd2,
        OP_OR  = 2'd3
    } op_t;

    // Instruction as popped from the instruction queue
    typedef struct packed {
        op_t        op;
        logic [3:0] tag;
        logic [3:0] rd;
        logic [3:0] rs1;
        logic [3:0] rs2;
    } res_word_t;

    // Fully-resolved operation handed to the ALU
    typedef struct packed {
        op_t         op;
        logic [3:0]  tag;
        logic [15:0] a;
        logic [15:0] b;
    } alu_word_t;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin arbiter. Grants the first set
//               request found scanning from i_ptr upward, wrapping modulo
//               NUM_REQ. Outputs a one-hot grant and the granted index.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PTR_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [PTR_W-1:0]   o_idx,
    output logic               o_valid
);

    // Candidate index k steps after the pointer; power-of-two sizing makes
    // the natural PTR_W-bit wrap equal to modulo NUM_REQ.
    logic [PTR_W-1:0] w_cand [NUM_REQ];

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_cand
        assign w_cand[k] = i_ptr + PTR_W'(k);
    end

    // Scan from farthest to nearest so the nearest requester wins last.
    always_comb begin
        o_idx   = '0;
        o_valid = 1'b0;
        o_grant = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (i_req[w_cand[k]]) begin
                o_idx   = w_cand[k];
                o_valid = 1'b1;
            end
        end
        o_grant[o_idx] = o_valid;
    end

endmodule

`default_nettype wire

// File: rtl/rs_issue_scheduler.sv
// ============================================================================
// Module      : rs_issue_scheduler
// Description : Allocates free reservation stations to queued instructions,
//               captures each station's start_exe word into a holding slot
//               and issues held words round-robin onto one shared ALU over a
//               valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rs_issue_scheduler
    import tomasula_types::*;
#(
    parameter int NUM_RS = NUM_RS_DEFAULT,
    parameter int PTR_W  = $clog2(NUM_RS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    // Dispatch side
    input  logic                         iq_valid,
    input  res_word_t                    iq_word,
    output logic                         iq_ready,
    input  logic [NUM_RS-1:0]            rs_empty,
    output logic [NUM_RS-1:0]            rs_load,
    output res_word_t                    rs_res_in,
    // Issue side
    input  logic [NUM_RS-1:0]            rs_start,
    input  alu_word_t [NUM_RS-1:0]       rs_alu_data,
    output logic                         alu_valid,
    input  logic                         alu_ready,
    output alu_word_t                    alu_data,
    output logic [PTR_W-1:0]             alu_src,
    output logic                         overflow_err
);

    logic [NUM_RS-1:0] r_pend;
    alu_word_t         r_hold [NUM_RS];
    logic [PTR_W-1:0]  r_rr_ptr;
    logic              r_overflow;

    logic              w_block;
    logic [NUM_RS-1:0] w_avail;
    logic [NUM_RS-1:0] w_lowest;
    logic [NUM_RS-1:0] w_grant;
    logic [PTR_W-1:0]  w_sel;
    logic              w_any_pend;
    logic              w_fire;
    logic [NUM_RS-1:0] w_capture;
    logic [NUM_RS-1:0] w_issue_clr;

    // Outputs to the queue, stations and ALU are silenced during rst/flush.
    assign w_block = rst | flush;

    // A station is allocatable only when empty and holding no unissued word.
    assign w_avail  = rs_empty & ~r_pend;
    assign w_lowest = w_avail & (~w_avail + NUM_RS'(1));

    assign iq_ready  = ~w_block & (|w_avail);
    assign rs_load   = (iq_valid & ~w_block) ? w_lowest : '0;
    assign rs_res_in = iq_word;

    rr_arbiter #(
        .NUM_REQ (NUM_RS),
        .PTR_W   (PTR_W)
    ) u_rr_arbiter (
        .i_req   (r_pend),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant),
        .o_idx   (w_sel),
        .o_valid (w_any_pend)
    );

    assign alu_valid    = w_any_pend & ~w_block;
    assign alu_data     = r_hold[w_sel];
    assign alu_src      = w_sel;
    assign overflow_err = r_overflow;

    assign w_fire      = alu_valid & alu_ready;
    // Capture only into free slots; a start on a pending slot is an overflow.
    assign w_capture   = rs_start & ~r_pend;
    assign w_issue_clr = w_fire ? w_grant : '0;

    // Pending flags, round-robin pointer and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend     <= '0;
            r_rr_ptr   <= '0;
            r_overflow <= 1'b0;
        end else if (flush) begin
            r_pend     <= '0;
            r_rr_ptr   <= '0;
        end else begin
            r_pend <= (r_pend & ~w_issue_clr) | w_capture;
            if (w_fire) begin
                r_rr_ptr <= w_sel + PTR_W'(1);
            end
            if (|(rs_start & r_pend)) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Holding slots latch the station's ALU word on its start pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_RS; i++) begin
                r_hold[i] <= '0;
            end
        end else if (!flush) begin
            for (int i = 0; i < NUM_RS; i++) begin
                if (w_capture[i]) begin
                    r_hold[i] <= rs_alu_data[i];
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rs_issue_scheduler.sv
// ============================================================================
// Module      : tb_rs_issue_scheduler
// Description : Directed self-checking bench for rs_issue_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rs_issue_scheduler;
    import tomasula_types::*;

    localparam int NUM_RS = 4;
    localparam int PTR_W  = 2;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   flush;
    logic                   iq_valid;
    res_word_t              iq_word;
    logic                   iq_ready;
    logic [NUM_RS-1:0]      rs_empty;
    logic [NUM_RS-1:0]      rs_load;
    res_word_t              rs_res_in;
    logic [NUM_RS-1:0]      rs_start;
    alu_word_t [NUM_RS-1:0] rs_alu_data;
    logic                   alu_valid;
    logic                   alu_ready;
    alu_word_t              alu_data;
    logic [PTR_W-1:0]       alu_src;
    logic                   overflow_err;

    int checks   = 0;
    int failures = 0;

    rs_issue_scheduler #(
        .NUM_RS (NUM_RS),
        .PTR_W  (PTR_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .iq_valid     (iq_valid),
        .iq_word      (iq_word),
        .iq_ready     (iq_ready),
        .rs_empty     (rs_empty),
        .rs_load      (rs_load),
        .rs_res_in    (rs_res_in),
        .rs_start     (rs_start),
        .rs_alu_data  (rs_alu_data),
        .alu_valid    (alu_valid),
        .alu_ready    (alu_ready),
        .alu_data     (alu_data),
        .alu_src      (alu_src),
        .overflow_err (overflow_err)
    );

    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("FAIL timeout observed=running required=finished");
        $fatal(1, "timeout");
    end

    function automatic alu_word_t mkw(input int tag);
        alu_word_t w;
        w.op  = OP_ADD;
        w.tag = 4'(tag);
        w.a   = 16'(16'h1000 + tag);
        w.b   = 16'(16'h2000 + tag * 3);
        return w;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are
    // sampled 1 ns after the edge, never on it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst         = 1'b1;
        flush       = 1'b0;
        iq_valid    = 1'b1;
        iq_word     = '{op: OP_SUB, tag: 4'h5, rd: 4'h1, rs1: 4'h2, rs2: 4'h3};
        rs_empty    = 4'b1111;
        rs_start    = 4'b0000;
        rs_alu_data = '0;
        alu_ready   = 1'b0;
        tick();
        tick();
        #1;
        // Outputs are forced quiet while in reset even with work available
        chk("rst_iq_ready", 64'(iq_ready), 64'd0);
        chk("rst_rs_load", 64'(rs_load), 64'd0);
        chk("rst_alu_valid", 64'(alu_valid), 64'd0);
        chk("rst_overflow", 64'(overflow_err), 64'd0);
        rst = 1'b0;
        iq_valid = 1'b0;
        rs_empty = 4'b0000;
        tick();

        // ---------------- Dispatch fill ----------------
        iq_valid = 1'b1;
        rs_empty = 4'b1111;
        #1;
        chk("fill0_load", 64'(rs_load), 64'b0001);
        chk("fill0_ready", 64'(iq_ready), 64'd1);
        chk("fill_res_in", 64'(rs_res_in), 64'(iq_word));
        tick(); rs_empty = 4'b1110; #1;
        chk("fill1_load", 64'(rs_load), 64'b0010);
        tick(); rs_empty = 4'b1100; #1;
        chk("fill2_load", 64'(rs_load), 64'b0100);
        tick(); rs_empty = 4'b1000; #1;
        chk("fill3_load", 64'(rs_load), 64'b1000);
        tick(); rs_empty = 4'b0000; #1;
        chk("full_ready", 64'(iq_ready), 64'd0);
        chk("full_load", 64'(rs_load), 64'd0);
        iq_valid = 1'b0;
        rs_empty = 4'b0100;
        #1;
        chk("noval_ready", 64'(iq_ready), 64'd1);
        chk("noval_load", 64'(rs_load), 64'd0);
        rs_empty = 4'b0000;

        // ---------------- Simultaneous start ----------------
        alu_ready = 1'b1;
        rs_start = 4'b1011;
        rs_alu_data[0] = mkw(1);
        rs_alu_data[1] = mkw(2);
        rs_alu_data[3] = mkw(4);
        #1;
        chk("sim_pre_valid", 64'(alu_valid), 64'd0);
        tick(); rs_start = 4'b0000; #1;
        chk("sim0_src", 64'(alu_src), 64'd0);
        chk("sim0_tag", 64'(alu_data.tag), 64'd1);
        tick();
        chk("sim1_src", 64'(alu_src), 64'd1);
        chk("sim1_tag", 64'(alu_data.tag), 64'd2);
        tick();
        chk("sim2_src", 64'(alu_src), 64'd3);
        chk("sim2_data", 64'(alu_data), 64'(mkw(4)));
        tick();
        chk("sim_drained", 64'(alu_valid), 64'd0);

        // ---------------- Backpressure (pointer at 0) ----------------
        alu_ready = 1'b0;
        rs_start = 4'b0100;
        rs_alu_data[2] = mkw(7);
        tick(); rs_start = 4'b0000;
        rs_alu_data[2] = mkw(9);
        for (int n = 0; n < 5; n++) begin
            #1;
            chk("bp_valid", 64'(alu_valid), 64'd1);
            chk("bp_data", 64'(alu_data), 64'(mkw(7)));
            chk("bp_src", 64'(alu_src), 64'd2);
            tick();
        end
        alu_ready = 1'b1;
        tick();
        chk("bp_once", 64'(alu_valid), 64'd0);
        // Pointer now 3: with 0 and 3 both pending, 3 goes first
        rs_start = 4'b1001;
        rs_alu_data[0] = mkw(8);
        rs_alu_data[3] = mkw(9);
        tick(); rs_start = 4'b0000; #1;
        chk("ptr3_src", 64'(alu_src), 64'd3);
        chk("ptr3_tag", 64'(alu_data.tag), 64'd9);
        tick();
        chk("ptr3_wrap_src", 64'(alu_src), 64'd0);
        chk("ptr3_wrap_tag", 64'(alu_data.tag), 64'd8);
        tick();
        chk("ptr3_drained", 64'(alu_valid), 64'd0);

        // ---------------- Fairness (pointer at 1) ----------------
        rs_start = 4'b0101;
        rs_alu_data[0] = mkw(10);
        rs_alu_data[2] = mkw(12);
        tick(); rs_start = 4'b0000;
        for (int n = 0; n < 6; n++) begin
            #1;
            chk("fair_src", 64'(alu_src), (n % 2 == 0) ? 64'd2 : 64'd0);
            chk("fair_tag", 64'(alu_data.tag), (n % 2 == 0) ? 64'(12 + n / 2) : 64'(10 + n / 2));
            // Re-dispatch the station granted on the previous cycle
            if (n == 0) begin
                rs_start = 4'b0000;
            end else if (n % 2 == 1) begin
                rs_start = 4'b0100;
                rs_alu_data[2] = mkw(12 + (n + 1) / 2);
            end else begin
                rs_start = 4'b0001;
                rs_alu_data[0] = mkw(10 + n / 2);
            end
            tick();
        end
        rs_start = 4'b0000;
        #1;
        chk("fair_last_src", 64'(alu_src), 64'd2);
        chk("fair_last_tag", 64'(alu_data.tag), 64'd15);
        tick();
        chk("fair_drained", 64'(alu_valid), 64'd0);
        chk("fair_no_ovf", 64'(overflow_err), 64'd0);

        // ---------------- Allocation block (pointer at 3) ----------------
        alu_ready = 1'b0;
        rs_start = 4'b0001;
        rs_alu_data[0] = mkw(5);
        tick(); rs_start = 4'b0000;
        iq_valid = 1'b1;
        rs_empty = 4'b0011;
        #1;
        chk("blk_load", 64'(rs_load), 64'b0010);
        rs_empty = 4'b0001;
        #1;
        chk("blk_ready", 64'(iq_ready), 64'd0);
        chk("blk_load0", 64'(rs_load), 64'd0);
        iq_valid = 1'b0;
        rs_empty = 4'b0000;

        // ---------------- Overflow ----------------
        rs_start = 4'b0010;
        rs_alu_data[1] = mkw(6);
        tick();
        rs_alu_data[1] = mkw(14);
        #1;
        chk("ovf_pre", 64'(overflow_err), 64'd0);
        tick(); rs_start = 4'b0000; #1;
        chk("ovf_set", 64'(overflow_err), 64'd1);
        chk("ovf_src0", 64'(alu_src), 64'd0);
        chk("ovf_tag0", 64'(alu_data.tag), 64'd5);
        alu_ready = 1'b1;
        tick();
        chk("ovf_src1", 64'(alu_src), 64'd1);
        chk("ovf_hold1", 64'(alu_data), 64'(mkw(6)));

        // ---------------- Flush (pointer at 1, all pending) ----------------
        alu_ready = 1'b0;
        rs_start = 4'b1101;
        rs_alu_data[0] = mkw(2);
        rs_alu_data[2] = mkw(3);
        rs_alu_data[3] = mkw(4);
        tick(); rs_start = 4'b0000; #1;
        chk("pre_flush_src", 64'(alu_src), 64'd1);
        flush = 1'b1;
        rs_start = 4'b0001;
        iq_valid = 1'b1;
        rs_empty = 4'b1111;
        #1;
        chk("flush_valid", 64'(alu_valid), 64'd0);
        chk("flush_ready", 64'(iq_ready), 64'd0);
        chk("flush_load", 64'(rs_load), 64'd0);
        tick();
        flush = 1'b0;
        rs_start = 4'b0000;
        iq_valid = 1'b0;
        rs_empty = 4'b0000;
        #1;
        chk("post_flush_valid", 64'(alu_valid), 64'd0);
        chk("post_flush_ovf", 64'(overflow_err), 64'd1);
        // Pointer back at 0: stations 0 and 1 pending, 0 is presented
        rs_start = 4'b0011;
        rs_alu_data[0] = mkw(11);
        rs_alu_data[1] = mkw(12);
        tick(); rs_start = 4'b0000; #1;
        chk("flush_ptr_src", 64'(alu_src), 64'd0);
        chk("flush_ptr_tag", 64'(alu_data.tag), 64'd11);

        // ---------------- Reset mid-handshake ----------------
        rst = 1'b1;
        #1;
        chk("rst_mid_valid", 64'(alu_valid), 64'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("rst_after_valid", 64'(alu_valid), 64'd0);
        chk("rst_ovf_clear", 64'(overflow_err), 64'd0);
        tick();
        chk("rst_stays_empty", 64'(alu_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
